// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elevator_pkg
// Description : Shared types and constants for the elevator scheduler:
//               FSM state encoding, default floor-index width and tick
//               counts, and request-search helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_e;

    localparam int FLOOR_W          = 2;
    localparam int NUM_FLOORS_DEF   = 3;
    localparam int FLOOR_TICKS_DEF  = 100000000;
    localparam int DOOR_TICKS_DEF   = 200000000;

    // Helpers take a fixed-width request vector so one definition serves any
    // floor count; callers zero-extend their pending vector.
    localparam int MAX_FLOORS = 32;

    function automatic logic any_above(input logic [MAX_FLOORS-1:0] pend,
                                       input logic [31:0]           floor);
        logic found;
        found = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if ($unsigned(i) > floor) begin
                found = found | pend[i];
            end
        end
        return found;
    endfunction

    function automatic logic any_below(input logic [MAX_FLOORS-1:0] pend,
                                       input logic [31:0]           floor);
        logic found;
        found = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if ($unsigned(i) < floor) begin
                found = found | pend[i];
            end
        end
        return found;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_timer.sv
`default_nettype none
// ============================================================================
// Module      : elevator_timer
// Description : Loadable down-counter shared by the travel and door phases.
//               expire is high during the cycle the count equals 1; the count
//               then parks at 0 until the next load.
// Ports       : clk, rst_n (async active-low), load, load_val[TIMER_W-1:0],
//               expire
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_timer #(
    parameter int TIMER_W = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               expire
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == TIMER_W'(1));

endmodule
`default_nettype wire

// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : elevator_scheduler
// Description : Call-button request latch and SCAN scheduler. Latches floor
//               calls, moves one floor per FLOOR_TICKS cycles toward pending
//               requests, holds the door for DOOR_TICKS cycles on service.
// Ports       : clk                      system clock
//               reset                    asynchronous active-low reset
//               call[NUM_FLOORS-1:0]     level call buttons, one per floor
//               cur_floor[FLOOR_W-1:0]   current floor index
//               dir_up                   travel / bias direction (1 = up)
//               moving                   high in MOVE
//               door_open                high in DOOR
//               arrive                   one-cycle pulse on each floor step
//               pending[NUM_FLOORS-1:0]  latched outstanding requests
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_scheduler #(
    parameter int NUM_FLOORS  = elevator_pkg::NUM_FLOORS_DEF,
    parameter int FLOOR_W     = elevator_pkg::FLOOR_W,
    parameter int FLOOR_TICKS = elevator_pkg::FLOOR_TICKS_DEF,
    parameter int DOOR_TICKS  = elevator_pkg::DOOR_TICKS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic                  arrive,
    output logic [NUM_FLOORS-1:0] pending
);

    import elevator_pkg::*;

    localparam int MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int TIMER_W   = $clog2(MAX_TICKS + 1);
    localparam logic [TIMER_W-1:0] FLOOR_LOAD = TIMER_W'(FLOOR_TICKS);
    localparam logic [TIMER_W-1:0] DOOR_LOAD  = TIMER_W'(DOOR_TICKS);

    state_e                  state_q, state_d;
    logic [FLOOR_W-1:0]      floor_q, floor_d;
    logic                    dir_q, dir_d;
    logic [NUM_FLOORS-1:0]   pend_q, pend_d;
    logic                    arrive_q, arrive_d;

    logic                    w_timer_load;
    logic [TIMER_W-1:0]      w_timer_val;
    logic                    w_timer_expire;
    logic [NUM_FLOORS-1:0]   w_clr;
    logic [FLOOR_W-1:0]      w_next_floor;
    logic [MAX_FLOORS-1:0]   w_pend_ext;
    logic                    w_req_above, w_req_below;
    logic                    w_next_above, w_next_below;

    assign w_pend_ext   = MAX_FLOORS'(pend_q);
    assign w_next_floor = dir_q ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));
    assign w_req_above  = any_above(w_pend_ext, 32'(floor_q));
    assign w_req_below  = any_below(w_pend_ext, 32'(floor_q));
    assign w_next_above = any_above(w_pend_ext, 32'(w_next_floor));
    assign w_next_below = any_below(w_pend_ext, 32'(w_next_floor));

    always_comb begin
        state_d      = state_q;
        floor_d      = floor_q;
        dir_d        = dir_q;
        arrive_d     = 1'b0;
        w_timer_load = 1'b0;
        w_timer_val  = FLOOR_LOAD;
        w_clr        = '0;

        case (state_q)
            IDLE: begin
                if (pend_q[floor_q]) begin
                    state_d      = DOOR;
                    w_clr        = NUM_FLOORS'(1) << floor_q;
                    w_timer_load = 1'b1;
                    w_timer_val  = DOOR_LOAD;
                end else if (w_req_above && (dir_q || !w_req_below)) begin
                    dir_d        = 1'b1;
                    state_d      = MOVE;
                    w_timer_load = 1'b1;
                end else if (w_req_below) begin
                    dir_d        = 1'b0;
                    state_d      = MOVE;
                    w_timer_load = 1'b1;
                end
            end

            MOVE: begin
                if (w_timer_expire) begin
                    // Step and decide at the new floor in the same cycle so a
                    // through-run carries straight on with no IDLE gap.
                    floor_d  = w_next_floor;
                    arrive_d = 1'b1;
                    if (pend_q[w_next_floor]) begin
                        state_d      = DOOR;
                        w_clr        = NUM_FLOORS'(1) << w_next_floor;
                        w_timer_load = 1'b1;
                        w_timer_val  = DOOR_LOAD;
                    end else if (dir_q ? w_next_above : w_next_below) begin
                        w_timer_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DOOR: begin
                // Calls at the serviced floor are swallowed for the whole
                // hold and never extend it.
                w_clr = NUM_FLOORS'(1) << floor_q;
                if (w_timer_expire) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        pend_d = (pend_q | call) & ~w_clr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            floor_q  <= '0;
            dir_q    <= 1'b1;
            pend_q   <= '0;
            arrive_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            arrive_q <= arrive_d;
        end
    end

    elevator_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (reset),
        .load     (w_timer_load),
        .load_val (w_timer_val),
        .expire   (w_timer_expire)
    );

    assign cur_floor = floor_q;
    assign dir_up    = dir_q;
    assign moving    = (state_q == MOVE);
    assign door_open = (state_q == DOOR);
    assign arrive    = arrive_q;
    assign pending   = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_elevator_scheduler
// Description : Directed bench for elevator_scheduler with an event
//               scoreboard (floor arrivals and door-open windows, each with
//               its expected cycle) plus direct output checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_scheduler;

    localparam int NF = 3;
    localparam int FW = 2;
    localparam int FT = 8;
    localparam int DT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NF-1:0] call = '0;
    logic [FW-1:0] cur_floor;
    logic          dir_up, moving, door_open, arrive;
    logic [NF-1:0] pending;

    elevator_scheduler #(
        .NUM_FLOORS  (NF),
        .FLOOR_W     (FW),
        .FLOOR_TICKS (FT),
        .DOOR_TICKS  (DT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .call      (call),
        .cur_floor (cur_floor),
        .dir_up    (dir_up),
        .moving    (moving),
        .door_open (door_open),
        .arrive    (arrive),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        kind;   // 0 = arrive pulse, 1 = door window
        logic [1:0]  floor;
        logic        dir;
        logic [15:0] cyc;    // arrive cycle / door-open first cycle
        logic [7:0]  len;    // door window length
    } ev_t;

    ev_t exp_q[$];
    int  n_tot  = 0;
    int  n_pass = 0;

    function automatic ev_t mk(input logic k, input int f, input logic d,
                               input int c, input int l);
        ev_t e;
        e.kind  = k;
        e.floor = 2'(f);
        e.dir   = d;
        e.cyc   = 16'(c);
        e.len   = 8'(l);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic sb_compare(input ev_t o);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("sb_unexpected_event", 64'(o), 64'(0));
        end else begin
            e = exp_q.pop_front();
            chk("sb_event", 64'(o), 64'(e));
        end
    endtask

    // Event monitor
    logic door_prev  = 1'b0;
    int   door_start = 0;
    int   mv_cnt     = 0;
    int   range_viol = 0;

    always @(negedge clk) begin
        if (moving) mv_cnt++;
        if (cur_floor > FW'(NF - 1)) range_viol++;
        if (arrive) sb_compare(mk(1'b0, int'(cur_floor), dir_up, cyc, 0));
        if (door_open && !door_prev) door_start = cyc;
        if (!door_open && door_prev)
            sb_compare(mk(1'b1, int'(cur_floor), dir_up, door_start, cyc - door_start));
        door_prev = door_open;
    end

    task automatic pulse(input logic [NF-1:0] v, output int t0);
        call = v;
        @(negedge clk);
        t0   = cyc;
        call = '0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'(0));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_floor",   64'(cur_floor), 64'(0));
        chk("rst_dir",     64'(dir_up),    64'(1));
        chk("rst_moving",  64'(moving),    64'(0));
        chk("rst_door",    64'(door_open), 64'(0));
        chk("rst_arrive",  64'(arrive),    64'(0));
        chk("rst_pending", 64'(pending),   64'(0));
        reset = 1'b1;
        @(negedge clk);

        // Floor 0 -> 2 through-run, then an absorbed call during the door hold
        pulse(3'b100, t0);
        chk("s1_pending_latched", 64'(pending), 64'(3'b100));
        exp_q.push_back(mk(1'b0, 1, 1'b1, t0 + 1 + FT, 0));
        exp_q.push_back(mk(1'b0, 2, 1'b1, t0 + 1 + 2*FT, 0));
        exp_q.push_back(mk(1'b1, 2, 1'b1, t0 + 1 + 2*FT, DT));
        @(negedge clk);
        chk("s1_moving", 64'(moving), 64'(1));
        wait_until(t0 + 2 + 2*FT);
        pulse(3'b100, t0);
        chk("s4_absorbed_pending", 64'(pending), 64'(0));
        chk("s4_door_still_open", 64'(door_open), 64'(1));
        drain("s1_drain");
        chk("s1_final_floor",   64'(cur_floor), 64'(2));
        chk("s1_final_dir",     64'(dir_up),    64'(1));
        chk("s1_final_pending", 64'(pending),   64'(0));
        chk("s1_final_idle",    64'({moving, door_open}), 64'(0));

        // Floor 2 -> 0, direction reverses
        pulse(3'b001, t0);
        exp_q.push_back(mk(1'b0, 1, 1'b0, t0 + 1 + FT, 0));
        exp_q.push_back(mk(1'b0, 0, 1'b0, t0 + 1 + 2*FT, 0));
        exp_q.push_back(mk(1'b1, 0, 1'b0, t0 + 1 + 2*FT, DT));
        drain("down_drain");
        chk("down_floor", 64'(cur_floor), 64'(0));

        // Call at the current floor: door only, no motion
        mv_cnt = 0;
        pulse(3'b001, t0);
        exp_q.push_back(mk(1'b1, 0, 1'b0, t0 + 1, DT));
        drain("s2_drain");
        chk("s2_no_motion", 64'(mv_cnt),    64'(0));
        chk("s2_floor",     64'(cur_floor), 64'(0));
        chk("s2_pending",   64'(pending),   64'(0));

        // Call added during travel: stop at 1, on to 2, back to 0
        pulse(3'b100, t0);
        exp_q.push_back(mk(1'b0, 1, 1'b1, t0 + 1 + FT, 0));
        exp_q.push_back(mk(1'b1, 1, 1'b1, t0 + 1 + FT, DT));
        exp_q.push_back(mk(1'b0, 2, 1'b1, t0 + 2 + 2*FT + DT, 0));
        exp_q.push_back(mk(1'b1, 2, 1'b1, t0 + 2 + 2*FT + DT, DT));
        exp_q.push_back(mk(1'b0, 1, 1'b0, t0 + 3 + 3*FT + 2*DT, 0));
        exp_q.push_back(mk(1'b0, 0, 1'b0, t0 + 3 + 4*FT + 2*DT, 0));
        exp_q.push_back(mk(1'b1, 0, 1'b0, t0 + 3 + 4*FT + 2*DT, DT));
        wait_until(t0 + 3);
        pulse(3'b011, t0);
        drain("s3_drain");
        chk("s3_pending", 64'(pending),   64'(0));
        chk("s3_floor",   64'(cur_floor), 64'(0));
        chk("s3_dir",     64'(dir_up),    64'(0));

        // Reach floor 1 heading up
        pulse(3'b010, t0);
        exp_q.push_back(mk(1'b0, 1, 1'b1, t0 + 1 + FT, 0));
        exp_q.push_back(mk(1'b1, 1, 1'b1, t0 + 1 + FT, DT));
        drain("s6_prep_drain");
        chk("s6_prep_dir", 64'(dir_up), 64'(1));

        // All calls at floor 1: door, up to 2, then down to 0
        pulse(3'b111, t0);
        exp_q.push_back(mk(1'b1, 1, 1'b1, t0 + 1, DT));
        exp_q.push_back(mk(1'b0, 2, 1'b1, t0 + 2 + FT + DT, 0));
        exp_q.push_back(mk(1'b1, 2, 1'b1, t0 + 2 + FT + DT, DT));
        exp_q.push_back(mk(1'b0, 1, 1'b0, t0 + 3 + 2*FT + 2*DT, 0));
        exp_q.push_back(mk(1'b0, 0, 1'b0, t0 + 3 + 3*FT + 2*DT, 0));
        exp_q.push_back(mk(1'b1, 0, 1'b0, t0 + 3 + 3*FT + 2*DT, DT));
        drain("s6_drain");
        chk("s6_pending", 64'(pending),   64'(0));
        chk("s6_floor",   64'(cur_floor), 64'(0));

        // Asynchronous reset in the middle of a move
        pulse(3'b010, t0);
        wait_until(t0 + 5);
        chk("s5_pre_moving", 64'(moving), 64'(1));
        reset = 1'b0;
        #1;
        chk("s5_async_moving",  64'(moving),    64'(0));
        chk("s5_async_pending", 64'(pending),   64'(0));
        chk("s5_async_door",    64'(door_open), 64'(0));
        chk("s5_async_floor",   64'(cur_floor), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        repeat (3*FT) @(negedge clk);
        chk("s5_after_floor",   64'(cur_floor), 64'(0));
        chk("s5_after_idle",    64'({moving, door_open}), 64'(0));
        chk("s5_after_pending", 64'(pending),   64'(0));
        chk("s5_after_dir",     64'(dir_up),    64'(1));

        chk("floor_range", 64'(range_viol), 64'(0));
        chk("sb_leftover", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
